// File: rtl/red_pitaya_lpf_scheduler_if.sv
// Port bundle for the time-multiplexed IIR filter bank: per-channel
// sample/config inputs on one side, filtered outputs and update strobes on the other.
interface red_pitaya_lpf_scheduler_if #(
    parameter int CHANNELS   = 4,
    parameter int SHIFTBITS  = 4,
    parameter int SIGNALBITS = 14
);
    logic [CHANNELS*SIGNALBITS-1:0]    signal_i;
    logic [CHANNELS*(SHIFTBITS+1)-1:0] shift_i;
    logic [CHANNELS-1:0]               enable_i;
    logic [CHANNELS-1:0]               highpass_i;
    logic [CHANNELS-1:0]               clear_i;
    logic [CHANNELS*SIGNALBITS-1:0]    signal_o;
    logic [CHANNELS-1:0]               valid_o;
    logic [$clog2(CHANNELS)-1:0]       slot_o;

    modport master (
        output signal_i, shift_i, enable_i, highpass_i, clear_i,
        input  signal_o, valid_o, slot_o
    );

    modport slave (
        input  signal_i, shift_i, enable_i, highpass_i, clear_i,
        output signal_o, valid_o, slot_o
    );
endinterface

// File: rtl/red_pitaya_lpf_scheduler.sv
// Shared first-order IIR low/high-pass datapath serving CHANNELS filter states,
// granted round-robin among enabled channels (grant/subtract stage, then accumulate stage).
module red_pitaya_lpf_scheduler #(
    parameter int CHANNELS   = 4,
    parameter int SHIFTBITS  = 4,
    parameter int SIGNALBITS = 14,
    parameter int MAXSHIFT   = 24
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    red_pitaya_lpf_scheduler_if.slave bus
);
    localparam int SW = SHIFTBITS + 1;
    localparam int YW = SIGNALBITS + MAXSHIFT;
    localparam int DW = SIGNALBITS + 1;
    localparam int CW = $clog2(CHANNELS);
    localparam int SB = SIGNALBITS;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    logic signed [SB-1:0] sig_in   [CHANNELS];
    logic        [SW-1:0] shift_in [CHANNELS];
    logic        [CHANNELS-1:0] eligible;

    logic signed [YW-1:0] y_q [CHANNELS];
    logic [CW-1:0]        ptr_q;

    logic                 v1_q;
    logic [CW-1:0]        ch1_q;
    logic                 hp1_q;
    logic signed [DW-1:0] delta1_q;
    logic [SW-1:0]        s1_q;

    logic [CHANNELS*SB-1:0] sig_out_q;
    logic [CHANNELS-1:0]    valid_q;
    logic [CW-1:0]          slot_q;

    logic                 grant_v;
    logic [CW-1:0]        grant_ch;
    logic [CW-1:0]        idx;
    logic                 wr2;
    logic signed [YW-1:0] inc2;
    logic signed [YW-1:0] y_new;
    logic signed [SB-1:0] yout_new;
    logic signed [SB-1:0] yout_g;
    logic signed [DW-1:0] delta_g;
    logic [SW-1:0]        shift_g;
    logic signed [SB-1:0] delta_sat;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sig_in[c]   = bus.signal_i[c*SB +: SB];
            shift_in[c] = bus.shift_i[c*SW +: SW];
        end
        eligible = bus.enable_i & ~bus.clear_i;
    end

    // First eligible channel strictly after the pointer, wrapping around.
    always_comb begin
        grant_v  = 1'b0;
        grant_ch = '0;
        idx      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = CW'((int'(ptr_q) + k) % CHANNELS);
            if (!grant_v && eligible[idx]) begin
                grant_v  = 1'b1;
                grant_ch = idx;
            end
        end
    end

    always_comb begin
        wr2      = v1_q && bus.enable_i[ch1_q] && !bus.clear_i[ch1_q];
        inc2     = {{(YW-DW){delta1_q[DW-1]}}, delta1_q} <<< s1_q;
        y_new    = y_q[ch1_q] + inc2;
        yout_new = y_new[YW-1:MAXSHIFT];

        // Single-channel operation grants the same channel back to back, so the
        // subtract must see the state being written on this same edge.
        if (wr2 && ch1_q == grant_ch)
            yout_g = yout_new;
        else
            yout_g = y_q[grant_ch][YW-1:MAXSHIFT];

        delta_g = {sig_in[grant_ch][SB-1], sig_in[grant_ch]} - {yout_g[SB-1], yout_g};

        if (int'(shift_in[grant_ch]) > MAXSHIFT)
            shift_g = SW'(MAXSHIFT);
        else
            shift_g = shift_in[grant_ch];

        if (delta1_q[DW-1] != delta1_q[DW-2])
            delta_sat = delta1_q[DW-1] ? {1'b1, {(SB-1){1'b0}}} : {1'b0, {(SB-1){1'b1}}};
        else
            delta_sat = delta1_q[SB-1:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q     <= LAST_CH;
            v1_q      <= 1'b0;
            ch1_q     <= '0;
            hp1_q     <= 1'b0;
            delta1_q  <= '0;
            s1_q      <= '0;
            sig_out_q <= '0;
            valid_q   <= '0;
            slot_q    <= '0;
            for (int c = 0; c < CHANNELS; c++)
                y_q[c] <= '0;
        end else begin
            v1_q <= grant_v;
            if (grant_v) begin
                ptr_q    <= grant_ch;
                ch1_q    <= grant_ch;
                hp1_q    <= bus.highpass_i[grant_ch];
                delta1_q <= delta_g;
                s1_q     <= shift_g;
            end
            if (wr2)
                slot_q <= ch1_q;

            // Disable and clear both win over an in-flight stage-2 write.
            for (int c = 0; c < CHANNELS; c++) begin
                if (!bus.enable_i[c]) begin
                    y_q[c]                <= '0;
                    sig_out_q[c*SB +: SB] <= sig_in[c];
                    valid_q[c]            <= 1'b0;
                end else if (bus.clear_i[c]) begin
                    y_q[c]     <= '0;
                    valid_q[c] <= 1'b0;
                end else if (wr2 && ch1_q == CW'(c)) begin
                    y_q[c]                <= y_new;
                    sig_out_q[c*SB +: SB] <= hp1_q ? delta_sat : yout_new;
                    valid_q[c]            <= 1'b1;
                end else begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    assign bus.signal_o = sig_out_q;
    assign bus.valid_o  = valid_q;
    assign bus.slot_o   = slot_q;

endmodule

// File: tb/tb_red_pitaya_lpf_scheduler.sv
// Directed bench for the shared-datapath IIR filter bank: step responses,
// clamped shift, clear, async reset and round-robin rotation.
module tb_red_pitaya_lpf_scheduler;
    logic clk_i;
    logic rstn_i;
    int   checks;
    int   errors;

    red_pitaya_lpf_scheduler_if #(.CHANNELS(4), .SHIFTBITS(4), .SIGNALBITS(14)) bus ();

    red_pitaya_lpf_scheduler #(
        .CHANNELS(4), .SHIFTBITS(4), .SIGNALBITS(14), .MAXSHIFT(24)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #4 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic signed [13:0] so(input int c);
        return bus.signal_o[c*14 +: 14];
    endfunction

    task automatic set_sig(input int c, input int v);
        bus.signal_i[c*14 +: 14] = 14'(v);
    endtask

    task automatic set_shift(input int c, input int v);
        bus.shift_i[c*5 +: 5] = 5'(v);
    endtask

    initial begin
        int lp_exp [4] = '{500, 750, 875, 937};
        int hp_exp [4] = '{1000, 500, 250, 125};
        logic [3:0] rr_valid [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int rr_slot [5] = '{0, 1, 2, 3, 0};

        checks = 0;
        errors = 0;
        rstn_i = 1'b0;
        bus.signal_i   = '0;
        bus.shift_i    = '0;
        bus.enable_i   = '0;
        bus.highpass_i = '0;
        bus.clear_i    = '0;

        repeat (3) tick();
        chk("reset_signal_o", 32'(bus.signal_o), 0);
        chk("reset_valid_o", bus.valid_o, 0);
        chk("reset_slot_o", bus.slot_o, 0);

        // Lowpass step, only ch0 enabled
        rstn_i = 1'b1;
        bus.enable_i = 4'b0001;
        set_shift(0, 23);
        tick();
        tick();
        set_sig(0, 1000);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lp_signal_o0", so(0), lp_exp[i]);
            chk("lp_valid_o0", bus.valid_o[0], 1);
            chk("lp_slot_o", bus.slot_o, 0);
        end

        // Disabled channel passes through, state forced to zero
        bus.enable_i = 4'b0000;
        tick();
        chk("disable_passthru0", so(0), 1000);
        chk("disable_valid_o", bus.valid_o, 0);

        // Highpass step
        bus.highpass_i = 4'b0001;
        bus.enable_i   = 4'b0001;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hp_signal_o0", so(0), hp_exp[i]);
            chk("hp_valid_o0", bus.valid_o[0], 1);
        end

        // Shift 31 clamps to 24: output tracks input immediately
        bus.enable_i   = 4'b0000;
        bus.highpass_i = 4'b0000;
        set_shift(0, 31);
        tick();
        bus.enable_i = 4'b0001;
        tick();
        tick();
        chk("track_signal_o0", so(0), 1000);
        tick();
        chk("track_hold_o0", so(0), 1000);

        // Clear while ch0 sits in stage 2
        bus.enable_i = 4'b0000;
        set_shift(0, 23);
        tick();
        bus.enable_i = 4'b0001;
        tick();
        bus.clear_i = 4'b0001;
        tick();
        chk("clear_valid_o0", bus.valid_o[0], 0);
        chk("clear_hold_o0", so(0), 1000);
        bus.clear_i = 4'b0000;
        tick();
        tick();
        chk("clear_restart_o0", so(0), 500);
        chk("clear_restart_valid", bus.valid_o[0], 1);

        // Async reset between edges
        #1;
        rstn_i = 1'b0;
        #1;
        chk("async_rst_signal_o", 32'(bus.signal_o), 0);
        chk("async_rst_valid_o", bus.valid_o, 0);
        chk("async_rst_slot_o", bus.slot_o, 0);
        bus.enable_i = 4'b1111;
        set_shift(1, 20);
        set_shift(2, 20);
        set_shift(3, 20);
        #1;
        rstn_i = 1'b1;

        // All four enabled: first grant is ch0, then rotation
        tick();
        chk("rr_fill_valid", bus.valid_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr4_valid_o", bus.valid_o, rr_valid[i]);
            chk("rr4_slot_o", bus.slot_o, rr_slot[i]);
        end

        // Only ch1 and ch3: alternate, ch0/ch2 pass through
        bus.enable_i = 4'b1010;
        set_sig(0, -300);
        set_sig(2, 123);
        tick();
        chk("rr2_valid_a", bus.valid_o, 4'b0010);
        chk("rr2_slot_a", bus.slot_o, 1);
        chk("rr2_pass0", so(0), -300);
        chk("rr2_pass2", so(2), 123);
        tick();
        chk("rr2_valid_b", bus.valid_o, 4'b1000);
        chk("rr2_slot_b", bus.slot_o, 3);
        tick();
        chk("rr2_valid_c", bus.valid_o, 4'b0010);
        chk("rr2_slot_c", bus.slot_o, 1);
        chk("rr2_pass0_hold", so(0), -300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/red_pitaya_lpf_scheduler.md
# red_pitaya_lpf_scheduler

Time-multiplexed first-order IIR low/high-pass filter bank: one shared subtract/shift/accumulate datapath serves CHANNELS independent filter states, granted round-robin among enabled channels. It sits between the ADC-side signal routing and the PID/output mux. It replaces per-channel filter instances where fabric is tight. Each channel keeps its own shift (bandwidth), highpass select, enable and clear. Effective per-channel update rate is 125 MHz divided by the number of enabled channels.

## Interface
- CHANNELS, 4: number of filter channels (2..16).
- SHIFTBITS, 4: shift field is SHIFTBITS+1 bits wide.
- SIGNALBITS, 14: signed signal width.
- MAXSHIFT, 24: fractional bits of each state; shift clamp value.

- clk_i  in  1  system clock, 125 MHz.
- rstn_i  in  1  reset; asynchronous, active-low.
- signal_i  in  CHANNELS*SIGNALBITS  signed inputs, channel c at bits [c*SIGNALBITS +: SIGNALBITS].
- shift_i  in  CHANNELS*(SHIFTBITS+1)  per-channel shift, unsigned; larger means higher bandwidth.
- enable_i  in  CHANNELS  per-channel filter on.
- highpass_i  in  CHANNELS  1 = output delta (highpass), 0 = output state (lowpass).
- clear_i  in  CHANNELS  synchronous per-channel state clear.
- signal_o  out  CHANNELS*SIGNALBITS  signed per-channel outputs, same packing as signal_i.
- valid_o  out  CHANNELS  one-cycle pulse when that channel's filtered output updates.
- slot_o  out  $clog2(CHANNELS)  index of the channel written in the current stage-2 cycle.

## Operation
- Per-channel state: y[c], signed SIGNALBITS+MAXSHIFT bits. The channel output is y_out[c] = y[c][MAXSHIFT+SIGNALBITS-1:MAXSHIFT].
- Arbiter: a round-robin pointer holds the last granted channel. Each cycle, the grant goes to the first channel after the pointer, cyclically, with enable_i=1 and clear_i=0. With no eligible channel, no grant is made: stage 1 is idle and the pointer is held.
- Stage 1 (granted channel g):
  - register ch1=g and hp1=highpass_i[g];
  - register delta1 = signal_i[g] − y_out[g], SIGNALBITS+1 bits signed, no truncation;
  - register s1 = min(shift_i[g], MAXSHIFT).
- Forwarding: if stage 2 writes channel g on the same edge, stage 1 uses the y_out of the value being written, not the stale register. This is mandatory; a single enabled channel is granted every cycle.
- Stage 2:
  - y[ch1] <= y[ch1] + sign_extend(delta1) << s1. The sum is SIGNALBITS+MAXSHIFT bits. No saturation is required, because s1≤MAXSHIFT keeps the result between the old state and the input.
  - signal_o[ch1] <= hp1 ? saturate(delta1 to SIGNALBITS) : new y_out.
  - valid_o[ch1] pulses; slot_o = ch1.
- Disabled channel (enable_i[c]=0):
  - y[c] is forced to 0;
  - signal_o[c] <= signal_i[c] every cycle (registered passthrough);
  - valid_o[c] stays 0.
- clear_i[c]=1 forces y[c] to 0 and blocks grants to c. signal_o[c] holds its last value.
- Clear or disable of ch1 arriving while ch1 is in stage 2: the clear takes precedence, so y[ch1] becomes 0 and valid_o is suppressed. A disable in this case makes that cycle's passthrough apply.
- The pointer advances to g on each grant. A channel enabled mid-cycle becomes eligible on the next arbitration.

## Timing
- Reset (async, rstn_i=0): all y=0, stage registers 0, signal_o=0, valid_o=0, slot_o=0. The pointer is set to CHANNELS-1, so the first grant after release is the lowest enabled index.
- Latency: signal_i is sampled at grant edge E; signal_o and valid_o for that sample are visible after edge E+1.
- Throughput: one channel update per clock.
- Update cadence: with N enabled channels, each channel updates once every N cycles.
- Passthrough latency: 1 cycle.
- Reset asserted mid-pipeline clears everything immediately. The in-flight write is lost.

## Test plan
- Setup for all scenarios: CHANNELS=4, MAXSHIFT=24; only ch0 enabled.
- Lowpass step response: shift=23, signal_i[0] steps 0→1000. Required: signal_o[0]=500,750,875,937 on consecutive cycles, valid_o[0]=1 every cycle. This checks forwarding.
- Highpass: same stimulus as lowpass with highpass_i[0]=1. Required: signal_o[0]=1000,500,250,125.
- Full tracking: shift_i[0]=31 (clamped to 24), input 1000. Required: signal_o[0]=1000 after 2 edges.
- Round-robin:
  - All four channels enabled: valid_o rotates 0,1,2,3,0… and slot_o matches.
  - Only channels 1 and 3 enabled: the rotation alternates 1,3. Channels 0 and 2 pass signal_i through after 1 cycle (e.g. −300 → −300) with valid_o=0.
- Clear and reset:
  - clear_i[0] pulsed while ch0 is in stage 2. Required: no valid_o[0] that cycle and y[0]=0; the next step response restarts at 500.
  - rstn_i dropped asynchronously mid-stream. Required: all outputs 0 before the next clock edge; the first grant after release is channel 0.
